// File: rtl/dm_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dm_port_arbiter_pkg;

    // Port ownership state.
    typedef enum logic {
        ARB_CPU = 1'b0,
        ARB_M1  = 1'b1
    } arb_state_e;

    // PC presented on the external port during secondary-master beats.
    localparam logic [31:0] M1_PC = 32'h0000_0000;

    // Bits needed to hold counter values 0 .. n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dm_port_arbiter.sv
// Arbitrates the external data-memory port between the CPU M-stage and a
// secondary master (M1). The CPU normally wins; a wait counter forces an M1
// grant after bounded starvation, and m1_lock holds the port for a short burst.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ARB_CPU | CPU has priority; M1 granted only when CPU idle or wait expired
// ARB_M1  | M1 holds the port for a locked burst while m1_req stays high
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT  = 8,
    parameter int BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    input  logic [31:0] cpu_pc,
    input  logic [3:0]  cpu_byte_we,
    output logic [31:0] cpu_rd,
    output logic        cpu_stall,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    input  logic [3:0]  m1_byte_we,
    output logic        m1_gnt,
    output logic [31:0] m1_rdata,
    output logic        m1_rvalid,
    output logic [31:0] data_addr,
    output logic [31:0] data_wd,
    output logic [31:0] data_pc,
    output logic [3:0]  data_byte_we,
    input  logic [31:0] data_rd
);

    localparam int WW = cnt_width(MAX_WAIT);
    localparam int BW = cnt_width(BURST_MAX);
    localparam logic [WW-1:0] WAIT_SAT  = WW'(MAX_WAIT - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);
    localparam logic          BURST_EN  = (BURST_MAX > 1);

    arb_state_e    state_q, state_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          sel_m1;

    // Port owner this cycle; shared by next-state and output logic.
    assign sel_m1 = (state_q == ARB_M1) ? m1_req
                  : (m1_req && (!cpu_req || (wait_cnt_q == WAIT_SAT)));

    // State, counters and M1 read-return registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_CPU;
            wait_cnt_q <= '0;
            beat_cnt_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // Next state: burst tracking, starvation counter, M1 read capture.
    always_comb begin
        state_d    = ARB_CPU;
        beat_cnt_d = '0;
        wait_cnt_d = wait_cnt_q;
        if (sel_m1 || !m1_req) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_SAT) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
        end
        case (state_q)
            ARB_CPU: begin
                if (sel_m1 && m1_lock && BURST_EN) begin
                    state_d    = ARB_M1;
                    beat_cnt_d = BW'(1);
                end
            end
            ARB_M1: begin
                // beat_cnt_q < BURST_MAX-1 leaves room for one more locked beat.
                if (m1_req && m1_lock && (beat_cnt_q < BEAT_LAST)) begin
                    state_d    = ARB_M1;
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end
            end
            default: ;
        endcase
        rvalid_d = sel_m1 && (m1_byte_we == 4'b0000);
        rdata_d  = rvalid_d ? data_rd : rdata_q;
    end

    // Output mux onto the external port and pipeline stall.
    always_comb begin
        data_addr    = cpu_addr;
        data_wd      = cpu_wd;
        data_pc      = cpu_pc;
        data_byte_we = cpu_byte_we & {4{cpu_req}};
        m1_gnt       = 1'b0;
        if (sel_m1) begin
            data_addr    = m1_addr;
            data_wd      = m1_wd;
            data_pc      = M1_PC;
            data_byte_we = m1_byte_we;
            m1_gnt       = 1'b1;
        end
        cpu_stall = cpu_req && sel_m1;
        cpu_rd    = data_rd;
    end

    assign m1_rdata  = rdata_q;
    assign m1_rvalid = rvalid_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed scenarios plus randomized traffic, all
// checked each cycle against a behavioural model of the arbitration rules.
module tb_dm_port_arbiter;

    localparam int MAX_WAIT  = 8;
    localparam int BURST_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, m1_req, m1_lock;
    logic [31:0] cpu_addr, cpu_wd, cpu_pc, m1_addr, m1_wd;
    logic [3:0]  cpu_byte_we, m1_byte_we;
    logic [31:0] cpu_rd, m1_rdata, data_addr, data_wd, data_pc, data_rd;
    logic        cpu_stall, m1_gnt, m1_rvalid;
    logic [3:0]  data_byte_we;

    dm_port_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_pc(cpu_pc),
        .cpu_byte_we(cpu_byte_we), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_byte_we(m1_byte_we), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .data_addr(data_addr), .data_wd(data_wd), .data_pc(data_pc),
        .data_byte_we(data_byte_we), .data_rd(data_rd)
    );

    always #5 clk = ~clk;

    // External memory: 16 words, combinational read.
    logic [31:0] mem [16];
    assign data_rd = mem[data_addr[5:2]];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: how long M1 has been refused, and how far into a locked burst.
    int          m1_waited = 0;
    bit          burst_on = 0;
    int          burst_beats = 0;
    bit          exp_rvalid = 0;
    logic [31:0] exp_rdata = '0;
    bit          last_gnt = 0, last_stall = 0;
    logic        obs_gnt, obs_stall, obs_rvalid;
    logic [31:0] obs_rd;

    // One clock cycle: inputs are already applied; check at negedge, advance model at posedge.
    task automatic cycle();
        logic        g;
        logic [31:0] ea, ewd, epc, erd;
        logic [3:0]  ebe;
        logic [3:0]  wr_idx;
        logic [31:0] wr_data;
        logic [3:0]  wr_be;
        @(negedge clk);
        g = m1_req && (burst_on || !cpu_req || (m1_waited >= MAX_WAIT - 1));
        if (g) begin
            ea = m1_addr; ewd = m1_wd; ebe = m1_byte_we; epc = 32'h0;
        end else begin
            ea = cpu_addr; ewd = cpu_wd; ebe = cpu_byte_we & {4{cpu_req}}; epc = cpu_pc;
        end
        erd = mem[ea[5:2]];
        chk("m1_gnt", m1_gnt, g);
        chk("cpu_stall", cpu_stall, cpu_req && g);
        chk("data_addr", data_addr, ea);
        chk("data_wd", data_wd, ewd);
        chk("data_byte_we", data_byte_we, ebe);
        chk("data_pc", data_pc, epc);
        chk("cpu_rd", cpu_rd, erd);
        chk("m1_rvalid", m1_rvalid, exp_rvalid);
        chk("m1_rdata", m1_rdata, exp_rdata);
        obs_gnt = m1_gnt; obs_stall = cpu_stall; obs_rd = cpu_rd; obs_rvalid = m1_rvalid;
        last_gnt = g; last_stall = cpu_req && g;
        wr_idx = data_addr[5:2]; wr_data = data_wd; wr_be = data_byte_we;
        @(posedge clk);
        if (reset) begin
            m1_waited = 0; burst_on = 0; burst_beats = 0;
            exp_rvalid = 0; exp_rdata = '0;
        end else begin
            exp_rvalid = g && (m1_byte_we == 4'b0000);
            if (exp_rvalid) exp_rdata = erd;
            if (g) begin
                m1_waited = 0;
                if (!burst_on) begin
                    if (m1_lock && BURST_MAX > 1) begin
                        burst_on = 1; burst_beats = 1;
                    end
                end else begin
                    burst_beats++;
                    if (!(m1_lock && burst_beats < BURST_MAX)) begin
                        burst_on = 0; burst_beats = 0;
                    end
                end
            end else begin
                burst_on = 0; burst_beats = 0;
                m1_waited = m1_req ? m1_waited + 1 : 0;
            end
        end
        #1;
        for (int b = 0; b < 4; b++)
            if (wr_be[b]) mem[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
    endtask

    function automatic logic [31:0] rand_addr();
        logic [3:0] idx;
        idx = 4'($urandom_range(0, 15));
        return {26'd0, idx, 2'b00};
    endfunction

    // Random traffic honouring the hold rules: stalled CPU and ungranted M1 keep their fields.
    task automatic drive_random();
        reset = ($urandom_range(0, 99) == 0);
        if (!last_stall) begin
            cpu_req     = ($urandom_range(0, 9) < 6);
            cpu_addr    = rand_addr();
            cpu_wd      = $urandom;
            cpu_pc      = $urandom;
            cpu_byte_we = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        end
        if (!(m1_req && !last_gnt)) begin
            m1_req     = ($urandom_range(0, 9) < 5);
            m1_lock    = ($urandom_range(0, 1) == 1);
            m1_addr    = rand_addr();
            m1_wd      = $urandom;
            m1_byte_we = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        end
    endtask

    initial begin
        int first_gnt;
        int beats;
        int gq[$];
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[8]  = 32'hDEAD_BEEF;
        mem[12] = 32'hCAFE_0030;
        reset = 1'b1;
        cpu_req = 0; cpu_addr = '0; cpu_wd = '0; cpu_pc = '0; cpu_byte_we = '0;
        m1_req = 0; m1_lock = 0; m1_addr = '0; m1_wd = '0; m1_byte_we = '0;
        @(posedge clk); #1;
        cycle();
        cycle();
        reset = 1'b0;

        // Reset state with nobody requesting.
        cycle();
        chk("rst_stall", obs_stall, 1'b0);
        chk("rst_rvalid", obs_rvalid, 1'b0);
        chk("rst_rdata", m1_rdata, 32'h0);

        // CPU-only word store.
        cpu_req = 1; cpu_addr = 32'h10; cpu_byte_we = 4'b1111; cpu_wd = 32'h1122_3344; cpu_pc = 32'h400;
        cycle();
        chk("cpu_only_stall", obs_stall, 1'b0);
        chk("cpu_only_mem", mem[4], 32'h1122_3344);

        // M1-only read of 0x20.
        cpu_req = 0; cpu_byte_we = 0;
        m1_req = 1; m1_lock = 0; m1_addr = 32'h20; m1_byte_we = 4'b0000;
        cycle();
        chk("m1_read_gnt", obs_gnt, 1'b1);
        m1_req = 0;
        chk("m1_read_rvalid", m1_rvalid, 1'b1);
        chk("m1_read_rdata", m1_rdata, 32'hDEAD_BEEF);
        cycle();

        // Contention: both held, M1 forced through on cycle MAX_WAIT.
        cpu_req = 1; cpu_addr = 32'h04; cpu_byte_we = 0;
        m1_req = 1; m1_lock = 0; m1_addr = 32'h24; m1_byte_we = 0;
        first_gnt = 0;
        for (int k = 1; k <= 9; k++) begin
            cycle();
            if (obs_gnt && first_gnt == 0) begin
                first_gnt = k;
                chk("contention_stall_on_gnt", obs_stall, 1'b1);
                m1_req = 0;
            end
            if (k == 9) chk("contention_cpu_resumes", obs_stall, 1'b0);
        end
        chk("contention_gnt_cycle", first_gnt, MAX_WAIT);

        // Locked burst of 6 requested beats against continuous CPU traffic.
        m1_req = 1; m1_lock = 1; m1_addr = 32'h00; m1_byte_we = 4'b1111; m1_wd = 32'hB000_0000;
        beats = 0;
        for (int k = 1; k <= 24; k++) begin
            cycle();
            if (obs_gnt) begin
                gq.push_back(k);
                beats++;
                m1_addr = 32'(beats * 4);
                m1_wd   = 32'hB000_0000 + 32'(beats);
                if (beats == 6) m1_req = 0;
            end
        end
        chk("burst_total_grants", gq.size(), 6);
        if (gq.size() >= 5) begin
            chk("burst_first_gnt", gq[0], 8);
            chk("burst_fourth_gnt", gq[3], 11);
            chk("burst_cpu_gap_then_gnt", gq[4], 19);
        end
        m1_lock = 0;

        // Lock drop after two beats; the stalled CPU load at 0x30 then completes.
        cpu_req = 0;
        m1_req = 1; m1_lock = 1; m1_addr = 32'h3C; m1_byte_we = 4'b1111; m1_wd = 32'h1111_0001;
        cycle();
        chk("lockdrop_beat1", obs_gnt, 1'b1);
        cpu_req = 1; cpu_addr = 32'h30; cpu_byte_we = 0; m1_wd = 32'h1111_0002;
        cycle();
        chk("lockdrop_beat2_stall", obs_stall, 1'b1);
        m1_req = 0; m1_lock = 0;
        cycle();
        chk("lockdrop_stall", obs_stall, 1'b0);
        chk("lockdrop_cpu_rd", obs_rd, 32'hCAFE_0030);

        // Reset asserted during beat 2 of a locked read burst.
        cpu_req = 0;
        m1_req = 1; m1_lock = 1; m1_addr = 32'h20; m1_byte_we = 0;
        cycle();
        cpu_req = 1; cpu_addr = 32'h08; reset = 1;
        cycle();
        reset = 0; m1_req = 0;
        cycle();
        chk("rst_burst_stall", obs_stall, 1'b0);
        chk("rst_burst_rvalid", obs_rvalid, 1'b0);
        m1_req = 1; m1_lock = 0;
        cycle();
        chk("rst_burst_cpu_own", obs_gnt, 1'b0);
        m1_req = 0;
        cycle();

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            drive_random();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
